y86_seq_ctrl: RTL and testbench

Y86_SEQ_CTRL -- requirements
Module: y86_seq_ctrl

---
 rtl/y86_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
// Sequential Y86 control FSM. It steps one instruction through the stages
// FETCH..PCUPD and parks in STOP on halt, fault or memory timeout.
module y86_seq_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic [3:0]  icode,
  input  logic [2:0]  stat_in,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dec_en,
  output logic        exe_en,
  output logic        wb_en,
  output logic        pc_we,
  output logic        cc_we,
  output logic [2:0]  state,
  output logic [2:0]  stat_out,
  output logic        busy,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_STOP      = 3'd7
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  icode_q, icode_d;
  logic [2:0]  stat_q, stat_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] cnt_q, cnt_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dec_en_q, dec_en_d;
  logic        exe_en_q, exe_en_d;
  logic        wb_en_q, wb_en_d;
  logic        pc_we_q, pc_we_d;
  logic        cc_we_q, cc_we_d;
  logic        busy_q, busy_d;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  function automatic logic needs_mem(input logic [3:0] code);
    case (code)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
      default:                           needs_mem = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          icode_d = icode;
          if (stat_in != STAT_AOK) begin
            state_d = S_STOP;
            stat_d  = stat_in;
          end else if (icode > 4'hB) begin
            state_d = S_STOP;
            stat_d  = STAT_INS;
          end else if (icode == 4'h0) begin
            state_d = S_STOP;
            stat_d  = STAT_HLT;
          end else begin
            state_d = S_DECODE;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (needs_mem(icode_q)) begin
          state_d = S_MEMORY;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (stat_in == STAT_ADR) begin
            state_d = S_STOP;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          stat_d  = STAT_ADR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
        if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so they line up with state_q.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEMORY);
    dec_en_d   = (state_d == S_DECODE);
    exe_en_d   = (state_d == S_EXECUTE);
    wb_en_d    = (state_d == S_WRITEBACK);
    pc_we_d    = (state_d == S_PCUPD);
    cc_we_d    = (state_d == S_EXECUTE) && (icode_d == 4'h6);
    busy_d     = (state_d != S_IDLE) && (state_d != S_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      icode_q    <= 4'h0;
      stat_q     <= STAT_AOK;
      wait_q     <= 8'd0;
      cnt_q      <= 32'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dec_en_q   <= 1'b0;
      exe_en_q   <= 1'b0;
      wb_en_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      cc_we_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      icode_q    <= icode_d;
      stat_q     <= stat_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dec_en_q   <= dec_en_d;
      exe_en_q   <= exe_en_d;
      wb_en_q    <= wb_en_d;
      pc_we_q    <= pc_we_d;
      cc_we_q    <= cc_we_d;
      busy_q     <= busy_d;
    end
  end

  assign state     = state_q;
  assign stat_out  = stat_q;
  assign instr_cnt = cnt_q;
  assign imem_req  = imem_req_q;
  assign dmem_req  = dmem_req_q;
  assign dec_en    = dec_en_q;
  assign exe_en    = exe_en_q;
  assign wb_en     = wb_en_q;
  assign pc_we     = pc_we_q;
  assign cc_we     = cc_we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed scoreboard bench for y86_seq_ctrl: each cycle's expected outputs
// are queued by the stimulus and compared by an independent monitor.
module tb_y86_seq_ctrl;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXE = 3'd3,
                         MEM = 3'd4, WB = 3'd5, PCU = 3'd6, STOP = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_ack, dmem_ack;
  logic [3:0]  icode;
  logic [2:0]  stat_in;
  logic        imem_req, dmem_req, dec_en, exe_en, wb_en, pc_we, cc_we, busy;
  logic [2:0]  state, stat_out;
  logic [31:0] instr_cnt;

  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req, dmem_req, dec_en, exe_en, wb_en, pc_we, cc_we, busy;
    logic [2:0]  so;
    logic [31:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  y86_seq_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .icode(icode), .stat_in(stat_in),
    .imem_req(imem_req), .dmem_req(dmem_req), .dec_en(dec_en),
    .exe_en(exe_en), .wb_en(wb_en), .pc_we(pc_we), .cc_we(cc_we),
    .state(state), .stat_out(stat_out), .busy(busy), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [2:0] st, input logic cc,
                               input logic [2:0] so, input logic [31:0] cnt);
    snap_t s;
    s.st       = st;
    s.imem_req = (st == FETCH);
    s.dmem_req = (st == MEM);
    s.dec_en   = (st == DEC);
    s.exe_en   = (st == EXE);
    s.wb_en    = (st == WB);
    s.pc_we    = (st == PCU);
    s.cc_we    = cc;
    s.busy     = (st >= FETCH) && (st <= PCU);
    s.so       = so;
    s.cnt      = cnt;
    return s;
  endfunction

  // Expectation for the clock edge about to happen, given the inputs already driven.
  task automatic cyc(input logic [2:0] st, input logic cc, input logic [2:0] so,
                     input logic [31:0] cnt, input string tag);
    @(posedge clk);
    #1;
    exp_q.push_back(mk(st, cc, so, cnt));
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    snap_t act, e;
    string t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = '{state, imem_req, dmem_req, dec_en, exe_en, wb_en, pc_we, cc_we,
              busy, stat_out, instr_cnt};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d req=%b%b en=%b%b%b%b cc=%b busy=%b so=%0d cnt=%0d, expected st=%0d req=%b%b en=%b%b%b%b cc=%b busy=%b so=%0d cnt=%0d",
                 t, act.st, act.imem_req, act.dmem_req, act.dec_en, act.exe_en,
                 act.wb_en, act.pc_we, act.cc_we, act.busy, act.so, act.cnt,
                 e.st, e.imem_req, e.dmem_req, e.dec_en, e.exe_en,
                 e.wb_en, e.pc_we, e.cc_we, e.busy, e.so, e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    icode = 4'h0; stat_in = 3'd1;

    // OPq (icode 6) with immediate acks, then a halt
    cyc(IDLE, 0, 1, 0, "reset");
    rst_n = 1'b1; start = 1'b1; icode = 4'h6; imem_ack = 1'b1; dmem_ack = 1'b1;
    cyc(FETCH, 0, 1, 0, "opq fetch");
    start = 1'b0;
    cyc(DEC, 0, 1, 0, "opq decode");
    icode = 4'hF;
    cyc(EXE, 1, 1, 0, "opq execute cc_we");
    cyc(WB, 0, 1, 0, "opq writeback");
    cyc(PCU, 0, 1, 0, "opq pcupd");
    cyc(FETCH, 0, 1, 1, "opq retired");
    icode = 4'h0;
    cyc(STOP, 0, 2, 1, "halt stop");
    start = 1'b1;
    cyc(STOP, 0, 2, 1, "stop ignores start");
    cyc(STOP, 0, 2, 1, "stop holds");

    // mrmovq with dmem_ack three cycles late, then an invalid icode
    rst_n = 1'b0; start = 1'b0;
    cyc(IDLE, 0, 1, 0, "reset from stop");
    rst_n = 1'b1; start = 1'b1; icode = 4'h5; imem_ack = 1'b1; dmem_ack = 1'b0;
    cyc(FETCH, 0, 1, 0, "mrm fetch");
    start = 1'b0;
    cyc(DEC, 0, 1, 0, "mrm decode");
    icode = 4'h0;
    cyc(EXE, 0, 1, 0, "mrm execute");
    cyc(MEM, 0, 1, 0, "mrm mem wait0");
    cyc(MEM, 0, 1, 0, "mrm mem wait1");
    cyc(MEM, 0, 1, 0, "mrm mem wait2");
    cyc(MEM, 0, 1, 0, "mrm mem wait3");
    dmem_ack = 1'b1;
    cyc(WB, 0, 1, 0, "mrm writeback");
    dmem_ack = 1'b0;
    cyc(PCU, 0, 1, 0, "mrm pcupd");
    cyc(FETCH, 0, 1, 1, "mrm retired");
    icode = 4'hC;
    cyc(STOP, 0, 4, 1, "bad icode stop");

    // imem never acks: 16 FETCH cycles then timeout
    rst_n = 1'b0;
    cyc(IDLE, 0, 1, 0, "reset before timeout");
    rst_n = 1'b1; start = 1'b1; imem_ack = 1'b0; icode = 4'h6;
    cyc(FETCH, 0, 1, 0, "timeout fetch 1");
    start = 1'b0;
    for (int i = 2; i <= 16; i++) cyc(FETCH, 0, 1, 0, $sformatf("timeout fetch %0d", i));
    cyc(STOP, 0, 3, 0, "fetch timeout stop");

    // rmmovq with entry-cycle dmem_ack and ADR status
    rst_n = 1'b0;
    cyc(IDLE, 0, 1, 0, "reset before adr");
    rst_n = 1'b1; start = 1'b1; icode = 4'h4; imem_ack = 1'b1; dmem_ack = 1'b1;
    stat_in = 3'd1;
    cyc(FETCH, 0, 1, 0, "rmm fetch");
    start = 1'b0;
    cyc(DEC, 0, 1, 0, "rmm decode");
    cyc(EXE, 0, 1, 0, "rmm execute");
    cyc(MEM, 0, 1, 0, "rmm mem");
    stat_in = 3'd3;
    cyc(STOP, 0, 3, 0, "dmem adr stop");

    // Reset beats start, then reset in the middle of a MEMORY wait
    rst_n = 1'b0; start = 1'b1; stat_in = 3'd1; dmem_ack = 1'b0;
    cyc(IDLE, 0, 1, 0, "reset dominates start");
    rst_n = 1'b1; icode = 4'h2;
    cyc(FETCH, 0, 1, 0, "rr fetch");
    start = 1'b0;
    cyc(DEC, 0, 1, 0, "rr decode");
    cyc(EXE, 0, 1, 0, "rr execute");
    cyc(WB, 0, 1, 0, "rr writeback");
    cyc(PCU, 0, 1, 0, "rr pcupd");
    cyc(FETCH, 0, 1, 1, "rr retired");
    icode = 4'hA;
    cyc(DEC, 0, 1, 1, "push decode");
    cyc(EXE, 0, 1, 1, "push execute");
    cyc(MEM, 0, 1, 1, "push mem");
    rst_n = 1'b0; dmem_ack = 1'b1;
    cyc(IDLE, 0, 1, 0, "reset in memory");

    // Fetch status outranks the halt code
    rst_n = 1'b1; start = 1'b1; icode = 4'h0; stat_in = 3'd4; dmem_ack = 1'b0;
    cyc(FETCH, 0, 1, 0, "stat fetch");
    start = 1'b0;
    cyc(STOP, 0, 4, 0, "stat_in priority stop");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
